// File: rtl/conv_layer_acc_pkg.sv
// Shared helpers for the conv_layer_acc MAC: width arithmetic,
// saturation-bound shift and the per-beat tag layout.
package conv_layer_acc_pkg;

  // Ceiling log2; clog2(1) is 0 so a 1x1 kernel or CIN=1 adds no bits.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Width of the registered adder-tree sum of KERNEL^2 products.
  function automatic int tree_w(input int n, input int m, input int k);
    return n + m + clog2(k * k);
  endfunction

  // Accumulator width; two spare bits keep bias + CIN tree sums in range.
  function automatic int acc_w(input int n, input int m, input int k, input int cin);
    return tree_w(n, m, k) + clog2(cin) + 2;
  endfunction

  // Bit position of the saturation limit: 2^sh - 1 is the largest output.
  function automatic int sat_shift(input int out_w, input int sgn);
    return (sgn != 0) ? out_w - 1 : out_w;
  endfunction

  // Control tags that ride along with every beat through the pipeline.
  typedef struct packed {
    logic first;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/conv_layer_acc_dot.sv
// conv_dot_kxk: KxK dot product in two registered stages.
// S1 registers the KERNEL^2 products, S2 registers the adder-tree sum.
// A valid bit and an opaque tag vector travel alongside the data.
module conv_dot_kxk
  import conv_layer_acc_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  input  logic [TAG_W-1:0]                    tag_in,
  input  logic [KERNEL*KERNEL*N-1:0]          data,
  input  logic [KERNEL*KERNEL*M-1:0]          w,
  output logic                                valid_out,
  output logic [TAG_W-1:0]                    tag_out,
  output logic [tree_w(N, M, KERNEL)-1:0]     sum
);

  localparam int KK = KERNEL * KERNEL;
  localparam int PW = N + M;
  localparam int TW = tree_w(N, M, KERNEL);

  logic [PW-1:0]    prod_c [KK];
  logic [PW-1:0]    prod_q [KK];
  logic             valid1;
  logic [TAG_W-1:0] tag1;
  logic [TW-1:0]    sum_c;

  // Element-wise products, extended to N+M bits before multiplying so the low bits are exact.
  always_comb begin
    for (int i = 0; i < KK; i++) begin
      if (SIGNED != 0) prod_c[i] = PW'($signed(data[i*N +: N])) * PW'($signed(w[i*M +: M]));
      else             prod_c[i] = PW'(data[i*N +: N]) * PW'(w[i*M +: M]);
    end
  end

  // S1 valid tag; cleared by reset so in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (rst) valid1 <= 1'b0;
    else     valid1 <= valid_in;
  end

  // S1 product and tag registers (datapath, no reset needed).
  always_ff @(posedge clk) begin
    prod_q <= prod_c;
    tag1   <= tag_in;
  end

  // Adder tree over the registered products, sign-extending in signed mode.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KK; i++) begin
      if (SIGNED != 0) sum_c = sum_c + TW'($signed(prod_q[i]));
      else             sum_c = sum_c + TW'(prod_q[i]);
    end
  end

  // S2 valid tag.
  always_ff @(posedge clk) begin
    if (rst) valid_out <= 1'b0;
    else     valid_out <= valid1;
  end

  // S2 sum and tag registers.
  always_ff @(posedge clk) begin
    sum     <= sum_c;
    tag_out <= tag1;
  end

endmodule

// File: rtl/conv_layer_acc.sv
// conv_layer_acc: multi-channel KxK convolution MAC.
// Beats (one input channel each) are accumulated over CIN channels, the
// bias is added on the first beat, and the pixel is saturated to OUT_W bits.
// Optional feature macro: CONV_ACC_RELU_EN (negative results output 0, signed mode only).
//
// Handshake: en_in is a valid-only strobe with no back-pressure; every cycle
// with en_in=1 is an accepted beat. en_out is a one-cycle valid for d_out and
// sat_out; d_out holds its value between pulses.
module conv_layer_acc
  import conv_layer_acc_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int CIN    = 4,
  parameter int SIGNED = 0,
  parameter int B_W    = 8,
  parameter int OUT_W  = N + M + 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_in,
  input  logic                       en_in,
  input  logic [KERNEL*KERNEL*N-1:0] data2conv,
  input  logic [KERNEL*KERNEL*M-1:0] w,
  input  logic [B_W-1:0]             bias,
  output logic [OUT_W-1:0]           d_out,
  output logic                       en_out,
  output logic                       sat_out
);

  localparam int KK     = KERNEL * KERNEL;
  localparam int TREE_W = tree_w(N, M, KERNEL);
  localparam int ACC_W  = acc_w(N, M, KERNEL, CIN);
  localparam int CNT_W  = (CIN > 1) ? clog2(CIN) : 1;
  localparam int FLAG_W = $bits(beat_tag_t);
  localparam int TAG_W  = FLAG_W + B_W;
  // Comparison width: one bit wider than either side so both bounds are representable.
  localparam int WW     = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int SH     = sat_shift(OUT_W, SIGNED);
  localparam logic signed [WW-1:0] SAT_HI = (WW'(1) << SH) - WW'(1);
  localparam logic signed [WW-1:0] SAT_LO = (SIGNED != 0) ? -(WW'(1) << SH) : '0;

  // Channel counter and beat classification
  logic [CNT_W-1:0] ch_cnt;
  logic [CNT_W-1:0] pos;
  logic             is_first;
  logic             is_last;

  // Input stage registers
  logic                  s0_valid;
  logic [KK*N-1:0]       s0_data;
  logic [KK*M-1:0]       s0_w;
  logic [TAG_W-1:0]      s0_tag;

  // Dot-product outputs (S2)
  logic                  s2_valid;
  logic [TAG_W-1:0]      s2_tag;
  logic [TREE_W-1:0]     s2_sum;
  beat_tag_t             s2_flags;
  logic [B_W-1:0]        s2_bias;

  // Accumulator stage (S3)
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      bias_ext;
  logic [ACC_W-1:0]      tree_ext;
  logic [ACC_W-1:0]      base;
  logic [ACC_W-1:0]      total;
  logic signed [WW-1:0]  wide;
  logic [OUT_W-1:0]      res;
  logic                  res_sat;

  // Position of the current beat inside its pixel; start_in restarts at channel 0.
  always_comb begin
    is_first = (ch_cnt == '0) || start_in;
    pos      = is_first ? '0 : ch_cnt;
    is_last  = (pos == CNT_W'(CIN - 1));
  end

  // Channel counter: advances only on accepted beats, wraps after the last channel.
  always_ff @(posedge clk) begin
    if (rst)        ch_cnt <= '0;
    else if (en_in) ch_cnt <= is_last ? '0 : pos + CNT_W'(1);
  end

  // Input valid tag.
  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= en_in;
  end

  // Register the beat together with its first/last/bias tags.
  always_ff @(posedge clk) begin
    s0_data <= data2conv;
    s0_w    <= w;
    s0_tag  <= {beat_tag_t'{first: is_first, last: is_last}, bias};
  end

  conv_dot_kxk #(
    .KERNEL (KERNEL),
    .N      (N),
    .M      (M),
    .SIGNED (SIGNED),
    .TAG_W  (TAG_W)
  ) u_dot (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (s0_valid),
    .tag_in    (s0_tag),
    .data      (s0_data),
    .w         (s0_w),
    .valid_out (s2_valid),
    .tag_out   (s2_tag),
    .sum       (s2_sum)
  );

  assign s2_flags = s2_tag[TAG_W-1 -: FLAG_W];
  assign s2_bias  = s2_tag[B_W-1:0];

  // Accumulate, then saturate (and optionally rectify) the pixel sum.
  always_comb begin
    if (SIGNED != 0) begin
      bias_ext = ACC_W'($signed(s2_bias));
      tree_ext = ACC_W'($signed(s2_sum));
    end else begin
      bias_ext = ACC_W'(s2_bias);
      tree_ext = ACC_W'(s2_sum);
    end
    base  = s2_flags.first ? bias_ext : acc;
    total = base + tree_ext;
    if (SIGNED != 0) wide = WW'($signed(total));
    else             wide = WW'(total);
    res     = wide[OUT_W-1:0];
    res_sat = 1'b0;
    if (wide > SAT_HI) begin
      res     = SAT_HI[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (wide < SAT_LO) begin
      res     = SAT_LO[OUT_W-1:0];
      res_sat = 1'b1;
    end
`ifdef CONV_ACC_RELU_EN
    if ((SIGNED != 0) && (wide < 0)) begin
      res     = '0;
      res_sat = 1'b0;
    end
`else
`endif
  end

  // S3: accumulator update and output pulse on the last beat of a pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      d_out   <= '0;
      en_out  <= 1'b0;
      sat_out <= 1'b0;
    end else begin
      en_out  <= 1'b0;
      sat_out <= 1'b0;
      if (s2_valid) begin
        acc <= total;
        if (s2_flags.last) begin
          d_out   <= res;
          en_out  <= 1'b1;
          sat_out <= res_sat;
        end
      end
    end
  end

endmodule
